// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: IF-stage next-PC prediction,
// ID-stage mispredict detection and redirect, table training and branch statistics.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] FetchPC,
  output logic        PredTaken,
  output logic [31:0] PredTarget,
  input  logic        ResolveValid,
  input  logic [31:0] ResolvePC,
  input  logic        ResolveTaken,
  input  logic [31:0] ResolveTarget,
  input  logic        ResolvePredTaken,
  input  logic [31:0] ResolvePredTarget,
  output logic        Mispredict,
  output logic [31:0] RedirectPC,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic             tbl_valid  [ENTRIES];
  logic [TAG_W-1:0] tbl_tag    [ENTRIES];
  logic [31:0]      tbl_target [ENTRIES];
  logic [1:0]       tbl_ctr    [ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             fetch_hit;
  logic [31:0]      fetch_seq;

  logic [IDX_W-1:0] res_idx;
  logic [TAG_W-1:0] res_tag;
  logic             res_hit;
  logic [31:0]      res_seq;
  logic             do_update;

  assign fetch_idx  = FetchPC[IDX_W+1:2];
  assign fetch_tag  = FetchPC[31:IDX_W+2];
  assign fetch_hit  = tbl_valid[fetch_idx] && (tbl_tag[fetch_idx] == fetch_tag);
  assign fetch_seq  = FetchPC + 32'd4;
  assign PredTaken  = fetch_hit && tbl_ctr[fetch_idx][1];
  assign PredTarget = PredTaken ? tbl_target[fetch_idx] : fetch_seq;

  assign res_idx   = ResolvePC[IDX_W+1:2];
  assign res_tag   = ResolvePC[31:IDX_W+2];
  assign res_hit   = tbl_valid[res_idx] && (tbl_tag[res_idx] == res_tag);
  assign res_seq   = ResolvePC + 32'd4;
  assign do_update = ResolveValid && !Rst;

  // A correct direction with a stale target still needs a redirect.
  assign Mispredict = do_update &&
                      ((ResolvePredTaken != ResolveTaken) ||
                       (ResolveTaken && (ResolvePredTarget != ResolveTarget)));
  assign RedirectPC = ResolveTaken ? ResolveTarget : res_seq;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_ctr[i]   <= 2'd1;
      end
      BranchCount     <= '0;
      MispredictCount <= '0;
    end else if (ResolveValid) begin
      BranchCount <= BranchCount + 32'd1;
      if (Mispredict) MispredictCount <= MispredictCount + 32'd1;
      if (res_hit) begin
        if (ResolveTaken) begin
          tbl_target[res_idx] <= ResolveTarget;
          if (tbl_ctr[res_idx] != 2'd3) tbl_ctr[res_idx] <= tbl_ctr[res_idx] + 2'd1;
        end else if (tbl_ctr[res_idx] != 2'd0) begin
          tbl_ctr[res_idx] <= tbl_ctr[res_idx] - 2'd1;
        end
      end else if (ResolveTaken) begin
        // Allocation evicts whatever occupied this index.
        tbl_valid[res_idx]  <= 1'b1;
        tbl_tag[res_idx]    <= res_tag;
        tbl_target[res_idx] <= ResolveTarget;
        tbl_ctr[res_idx]    <= 2'd2;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-computed vectors checked with
// immediate assertions; 16-entry table, so 0x00400010 and 0x00400050 alias.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        resolve_pred_taken;
  logic [31:0] resolve_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
    .Clk               (clk),
    .Rst               (rst),
    .FetchPC           (fetch_pc),
    .PredTaken         (pred_taken),
    .PredTarget        (pred_target),
    .ResolveValid      (resolve_valid),
    .ResolvePC         (resolve_pc),
    .ResolveTaken      (resolve_taken),
    .ResolveTarget     (resolve_target),
    .ResolvePredTaken  (resolve_pred_taken),
    .ResolvePredTarget (resolve_pred_target),
    .Mispredict        (mispredict),
    .RedirectPC        (redirect_pc),
    .BranchCount       (branch_count),
    .MispredictCount   (mispredict_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    resolve_valid       = v;
    resolve_pc          = pc;
    resolve_taken       = tk;
    resolve_target      = tgt;
    resolve_pred_taken  = ptk;
    resolve_pred_target = ptgt;
    #1;
  endtask

  task automatic idle();
    resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic exp_tk, input logic [31:0] exp_tgt,
                       input string tag);
    fetch_pc = pc;
    #1;
    check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
    check({tag, "_target"}, pred_target, exp_tgt);
  endtask

  task automatic counts(input logic [31:0] bc, input logic [31:0] mc, input string tag);
    check({tag, "_branch_count"}, branch_count, bc);
    check({tag, "_mispredict_count"}, mispredict_count, mc);
  endtask

  initial begin
    rst      = 1'b1;
    fetch_pc = 32'h0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    fetch(32'h0040_0010, 1'b0, 32'h0040_0014, "reset_fetch");
    counts(32'd0, 32'd0, "reset");
    check("reset_mispredict", {31'd0, mispredict}, 32'd0);

    // First taken branch misses and allocates; same-cycle lookup sees old table
    resolve(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    check("alloc_mispredict", {31'd0, mispredict}, 32'd1);
    check("alloc_redirect", redirect_pc, 32'h0040_0100);
    fetch(32'h0040_0010, 1'b0, 32'h0040_0014, "no_bypass");
    tick();
    idle();
    fetch(32'h0040_0010, 1'b1, 32'h0040_0100, "after_alloc");
    counts(32'd1, 32'd1, "after_alloc");

    // Correctly predicted taken: ctr 2->3
    resolve(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100);
    check("correct_taken_mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    idle();
    counts(32'd2, 32'd1, "after_taken");

    // Not taken: ctr 3->2, still predicts taken
    resolve(1'b1, 32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
    check("nt1_mispredict", {31'd0, mispredict}, 32'd1);
    check("nt1_redirect", redirect_pc, 32'h0040_0014);
    tick();
    idle();
    fetch(32'h0040_0010, 1'b1, 32'h0040_0100, "ctr2");

    // Not taken from ctr=2: mispredict, ctr->1, now predicts not taken
    resolve(1'b1, 32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
    check("nt2_mispredict", {31'd0, mispredict}, 32'd1);
    check("nt2_redirect", redirect_pc, 32'h0040_0014);
    tick();
    idle();
    fetch(32'h0040_0010, 1'b0, 32'h0040_0014, "ctr1");
    counts(32'd4, 32'd3, "after_nt");

    // Aliasing branch replaces the entry at index 4
    resolve(1'b1, 32'h0040_0050, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0054);
    check("alias_mispredict", {31'd0, mispredict}, 32'd1);
    tick();
    idle();
    fetch(32'h0040_0010, 1'b0, 32'h0040_0014, "alias_old");
    fetch(32'h0040_0050, 1'b1, 32'h0040_0200, "alias_new");

    // Right direction, wrong target: redirect and retarget
    resolve(1'b1, 32'h0040_0050, 1'b1, 32'h0040_0280, 1'b1, 32'h0040_0200);
    check("tgt_mispredict", {31'd0, mispredict}, 32'd1);
    check("tgt_redirect", redirect_pc, 32'h0040_0280);
    tick();
    idle();
    fetch(32'h0040_0050, 1'b1, 32'h0040_0280, "retarget");
    counts(32'd6, 32'd5, "after_retarget");

    // Address wrap on both adders; miss + not taken leaves table alone
    fetch(32'hFFFF_FFFC, 1'b0, 32'h0000_0000, "fetch_wrap");
    resolve(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_1000, 1'b1, 32'h0000_1000);
    check("wrap_mispredict", {31'd0, mispredict}, 32'd1);
    check("wrap_redirect", redirect_pc, 32'h0000_0000);
    tick();
    idle();
    fetch(32'hFFFF_FFFC, 1'b0, 32'h0000_0000, "miss_nt_unchanged");

    // ctr is 3 after retarget; another taken must saturate, so one NT leaves it taken
    resolve(1'b1, 32'h0040_0050, 1'b1, 32'h0040_0280, 1'b1, 32'h0040_0280);
    check("sat_mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    resolve(1'b1, 32'h0040_0050, 1'b0, 32'h0040_0280, 1'b1, 32'h0040_0280);
    tick();
    idle();
    fetch(32'h0040_0050, 1'b1, 32'h0040_0280, "saturate");
    counts(32'd9,32'd7, "after_sat");

    // Reset wins over a mispredicting resolve in the same cycle
    rst = 1'b1;
    resolve(1'b1, 32'h0040_0020, 1'b1, 32'h0040_0400, 1'b0, 32'h0040_0024);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    counts(32'd0, 32'd0, "rst_resolve");
    fetch(32'h0040_0020, 1'b0, 32'h0040_0024, "rst_no_alloc");
    fetch(32'h0040_0050, 1'b0, 32'h0040_0054, "rst_cleared");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side branch predictor and resolution checker for the pipelined MIPS core. In IF it predicts next-PC for the current fetch address from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. In ID it takes the resolved branch outcome from the branch comparator, flags a mispredict, supplies the corrected PC, and trains the table. It also keeps branch and mispredict statistics.

## Interface
- ENTRIES, 16: number of BTB entries; power of two, 4..256.
- IDX_W, 4: log2(ENTRIES).

- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- FetchPC  in  32  IF-stage PC; word aligned.
- PredTaken  out  1  IF prediction: branch taken.
- PredTarget  out  32  IF predicted next PC.
- ResolveValid  in  1  ID holds a conditional branch this cycle (beq/bne/bgez/bltz/blez/bgtz).
- ResolvePC  in  32  PC of the resolving branch.
- ResolveTaken  in  1  comparator outcome.
- ResolveTarget  in  32  computed branch target.
- ResolvePredTaken  in  1  PredTaken piped along with the branch.
- ResolvePredTarget  in  32  PredTarget piped along with the branch.
- Mispredict  out  1  flush IF/ID and redirect fetch.
- RedirectPC  out  32  correct next PC when Mispredict=1.
- BranchCount  out  32  resolved branches since reset.
- MispredictCount  out  32  mispredicts since reset.

## Operation
- Entry fields: valid, tag = PC[31:IDX_W+2], target[31:0], ctr[1:0]. Index = PC[IDX_W+1:2].
- Lookup (combinational from registered table):
  - hit = valid && tag match at FetchPC index.
  - PredTaken = hit && ctr[1].
  - PredTarget = stored target if PredTaken, else FetchPC+4. Adder is 32-bit and wraps (0xFFFFFFFC -> 0x00000000).
- Resolve (combinational, same cycle as ResolveValid):
  - actual = ResolveTaken ? ResolveTarget : ResolvePC+4.
  - Mispredict = ResolveValid && !Rst && (ResolvePredTaken != ResolveTaken || (ResolveTaken && ResolvePredTarget != ResolveTarget)).
  - RedirectPC = actual, always driven. It is only meaningful when Mispredict=1.
- Update (at the clock edge when ResolveValid && !Rst):
  - Tag hit: ctr increments on taken and decrements on not-taken, saturating at 3 and 0. Target is overwritten with ResolveTarget when taken.
  - Miss and taken: allocate the entry. Set valid=1, tag, target=ResolveTarget, ctr=2 (weakly taken). This replaces any existing occupant.
  - Miss and not taken: table unchanged.
  - BranchCount += 1. MispredictCount += 1 if Mispredict. Both wrap modulo 2^32.
- Counter states: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T. Predict taken iff state ≥ 2.

## Timing
- Prediction has zero-cycle latency: PredTaken/PredTarget depend only on FetchPC and the table state.
- Mispredict/RedirectPC have zero-cycle latency. The pipeline flushes on the same edge that trains the table.
- Table writes take effect on the edge. A lookup in the same cycle, even to the same index, sees the pre-update contents; there is no bypass.
- Reset (Rst=1 at an edge):
  - All valid bits clear, all ctr=1, BranchCount=MispredictCount=0.
  - Targets and tags are don't-care.
  - After reset, PredTaken=0 and PredTarget=FetchPC+4.
- Rst has priority over ResolveValid. A branch resolving in the same cycle as reset is neither counted nor trained, and Mispredict stays 0.
- Stalls: the pipeline deasserts ResolveValid while ID is stalled, so each branch is trained and counted exactly once.

## Test plan
- Reset, then FetchPC=0x00400010 -> PredTaken=0, PredTarget=0x00400014, both counts 0.
- Resolve PC=0x00400010 taken to 0x00400100 with ResolvePredTaken=0 -> Mispredict=1 and RedirectPC=0x00400100 that cycle. Next cycle, fetch of 0x00400010 gives PredTaken=1, PredTarget=0x00400100, BranchCount=1, MispredictCount=1.
- Same branch: taken, then not-taken ×2 -> ctr goes 2→3→2→1. Fetch then gives PredTaken=0. The not-taken resolve from ctr=2 raises Mispredict with RedirectPC=0x00400014.
- Aliasing: allocate 0x00400010 taken, then resolve 0x00400050 (same index for ENTRIES=16, different tag) taken to 0x00400200 -> entry replaced. Fetch 0x00400010 now misses (PredTaken=0).
- Correct direction, wrong target: PredTaken=1, PredTarget=0x100, ResolveTaken=1, ResolveTarget=0x200 -> Mispredict=1, RedirectPC=0x200, stored target becomes 0x200.
- Rst asserted in the same cycle as a mispredicting ResolveValid -> Mispredict=0, counts 0, and the entry is not allocated.
